branch_resolve_unit: RTL

Parametrised, registered successor to the single-slot combinational branch evaluator. It resolves up to NUM_BR branch/jump slots of one VLIW bundle per cycle and selects the oldest (lowest-index) taken slot. It drives a redirect handshake to fetch, then holds issue for a programmable flush window. It sits between operand-forwarding in issue and the fetch PC mux.

---
 rtl/bru_pkg.sv | 38 +++
 rtl/bru_slot_eval.sv | 54 +++++
 rtl/branch_resolve_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bru_pkg.sv
// rtl/bru_pkg.sv - shared types for the branch resolve unit and its slot evaluator
package bru_pkg;

  localparam int BRU_XLEN = 32;
  localparam int BRU_IMM_W = 20;

  typedef enum logic [1:0] {
    BEQ = 2'd0,
    BNE = 2'd1,
    BLT = 2'd2,
    BGE = 2'd3
  } br_op_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } bru_state_e;

  typedef struct packed {
    logic                 nop;
    logic                 jmp;
    logic                 imm_type;
    logic                 zero_ext;
    br_op_e               op;
    logic [BRU_XLEN-1:0]  rs1;
    logic [BRU_XLEN-1:0]  rs2;
    logic [BRU_IMM_W-1:0] imm;
  } bru_slot_req_t;

  typedef struct packed {
    logic                taken;
    logic [BRU_XLEN-1:0] target;
    logic                rd_wr_en;
    logic [BRU_XLEN-1:0] ret_addr;
  } bru_slot_res_t;

endpackage

// File: rtl/bru_slot_eval.sv
// rtl/bru_slot_eval.sv - combinational single-slot branch/jump evaluator
module bru_slot_eval
  import bru_pkg::*;
#(
  parameter int SLOT_SHIFT = 4
) (
  input  logic [BRU_XLEN-1:0] pc,
  input  bru_slot_req_t       req,
  output bru_slot_res_t       res
);

  logic [BRU_XLEN-1:0] imm12;
  logic [BRU_XLEN-1:0] imm20;
  logic [BRU_XLEN-1:0] jalr_sum;
  logic                eq;
  logic                lt;
  logic                cond;

  assign imm12    = {{(BRU_XLEN-12){req.imm[11]}}, req.imm[11:0]};
  assign imm20    = {{(BRU_XLEN-20){req.imm[19]}}, req.imm[19:0]};
  assign jalr_sum = req.rs1 + imm12;
  assign eq       = (req.rs1 == req.rs2);
  assign lt       = req.zero_ext ? (req.rs1 < req.rs2)
                                 : ($signed(req.rs1) < $signed(req.rs2));

  always_comb begin
    cond = 1'b0;
    case (req.op)
      BEQ:     cond = eq;
      BNE:     cond = ~eq;
      BLT:     cond = lt;
      BGE:     cond = ~lt;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    res = '0;
    if (!req.nop) begin
      res.ret_addr = pc + (BRU_XLEN'(1) << SLOT_SHIFT);
      if (req.jmp) begin
        res.taken    = 1'b1;
        res.rd_wr_en = 1'b1;
        // JALR targets are bundle-aligned, so the low offset bits are dropped
        res.target   = req.imm_type ? (jalr_sum & ({BRU_XLEN{1'b1}} << SLOT_SHIFT))
                                    : (pc + (imm20 << SLOT_SHIFT));
      end else begin
        res.taken  = cond;
        res.target = pc + (imm12 << SLOT_SHIFT);
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered multi-slot branch resolver with redirect/flush FSM
// Optional perf counters under BRU_PERF_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int XLEN         = BRU_XLEN,
  parameter int NUM_BR       = 2,
  parameter int SLOT_SHIFT   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        pc,
  input  logic [NUM_BR-1:0]      slot_nop,
  input  logic [NUM_BR-1:0]      slot_jmp,
  input  logic [NUM_BR-1:0]      slot_imm_type,
  input  logic [NUM_BR-1:0]      slot_zero_ext,
  input  logic [NUM_BR*2-1:0]    slot_op,
  input  logic [NUM_BR*XLEN-1:0] slot_rs1,
  input  logic [NUM_BR*XLEN-1:0] slot_rs2,
  input  logic [NUM_BR*20-1:0]   slot_imm,
  output logic                   res_valid,
  output logic [NUM_BR-1:0]      res_rd_wr_en,
  output logic [NUM_BR*XLEN-1:0] res_ret_addr,
  output logic                   flush,
  output logic                   redirect_valid,
  input  logic                   redirect_ready,
  output logic [XLEN-1:0]        redirect_pc
`ifdef BRU_PERF_EN
  ,
  output logic [31:0]            perf_taken_cnt,
  output logic [31:0]            perf_redirect_stall_cnt
`endif
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] FC_LOAD = CW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  bru_slot_req_t req [NUM_BR];
  bru_slot_res_t res [NUM_BR];

  for (genvar g = 0; g < NUM_BR; g++) begin : g_slot
    assign req[g] = '{
      nop:      slot_nop[g],
      jmp:      slot_jmp[g],
      imm_type: slot_imm_type[g],
      zero_ext: slot_zero_ext[g],
      op:       br_op_e'(slot_op[g*2 +: 2]),
      rs1:      slot_rs1[g*XLEN +: XLEN],
      rs2:      slot_rs2[g*XLEN +: XLEN],
      imm:      slot_imm[g*20 +: 20]
    };
    bru_slot_eval #(.SLOT_SHIFT(SLOT_SHIFT)) u_eval (
      .pc  (pc),
      .req (req[g]),
      .res (res[g])
    );
  end

  bru_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   accept;
  logic                   win_found;
  logic [XLEN-1:0]        win_target;
  logic [NUM_BR-1:0]      rd_wr_d;
  logic [NUM_BR*XLEN-1:0] ret_d;

  assign in_ready       = (state_q == RUN);
  assign redirect_valid = (state_q == REDIRECT);
  assign accept         = in_valid && in_ready;

  // Oldest taken slot wins; link writes of younger slots are squashed
  always_comb begin
    win_found  = 1'b0;
    win_target = '0;
    rd_wr_d    = '0;
    ret_d      = '0;
    for (int i = 0; i < NUM_BR; i++) begin
      rd_wr_d[i]              = res[i].rd_wr_en & ~win_found;
      ret_d[i*XLEN +: XLEN]   = res[i].ret_addr;
      if (res[i].taken && !win_found) begin
        win_found  = 1'b1;
        win_target = res[i].target;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (accept && win_found) state_d = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          if (FLUSH_CYCLES > 0) begin
            state_d = FLUSH;
            cnt_d   = FC_LOAD;
          end else begin
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid    <= 1'b0;
      res_rd_wr_en <= '0;
      res_ret_addr <= '0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      res_valid <= accept;
      flush     <= accept && win_found;
      if (accept) begin
        res_rd_wr_en <= rd_wr_d;
        res_ret_addr <= ret_d;
      end
      if (accept && win_found) redirect_pc <= win_target;
    end
  end

`ifdef BRU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_taken_cnt          <= '0;
      perf_redirect_stall_cnt <= '0;
    end else begin
      if (accept && win_found && (perf_taken_cnt != '1))
        perf_taken_cnt <= perf_taken_cnt + 32'd1;
      if ((state_q == REDIRECT) && !redirect_ready && (perf_redirect_stall_cnt != '1))
        perf_redirect_stall_cnt <= perf_redirect_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
